// File: rtl/wb_serial_tx.sv
// Wishbone-slave serial transmitter: bus writes queue words in a FIFO, and each
// word is sent on data_o as a framed serial word (START slot, bits, GAP).
module wb_serial_tx #(
  parameter int unsigned DATA_W     = 10,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned DIV_RST    = 4
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        CYC_I,
  input  logic        STB_I,
  input  logic        WE_I,
  input  logic [31:0] ADR_I,
  input  logic [31:0] DAT_I,
  output logic [31:0] DAT_O,
  output logic        ACK_O,
  output logic        data_o,
  output logic        ena_o
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned BIT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_SHIFT, S_GAP} state_e;

  state_e            state_q, state_d;
  logic              ack_q, ack_d;
  logic [31:0]       dat_q, dat_d;
  logic              en_q, en_d;
  logic              msb_q, msb_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              ovf_q, ovf_d;
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [CNT_W-1:0]  lvl_q, lvl_d;
  logic [DIV_W-1:0]  tmr_q, tmr_d;
  logic [DIV_W-1:0]  fdiv_q, fdiv_d;
  logic              fmsb_q, fmsb_d;
  logic [BIT_W-1:0]  bits_q, bits_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic              data_q, data_d;
  logic              ena_q, ena_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

  logic              req, acc, wr;
  logic [1:0]        sel;
  logic              empty, full, busy;
  logic              push, pop;
  logic [DIV_W-1:0]  div_eff;
  logic [31:0]       status;
  logic              unused_bits;

  assign req     = CYC_I & STB_I;
  assign acc     = ack_q & req;
  assign wr      = acc & WE_I;
  assign sel     = ADR_I[3:2];
  assign empty   = (lvl_q == '0);
  assign full    = (lvl_q == CNT_W'(FIFO_DEPTH));
  assign busy    = (state_q != S_IDLE);
  assign div_eff = (div_q < DIV_W'(2)) ? DIV_W'(2) : div_q;
  assign unused_bits = ^{ADR_I[31:4], ADR_I[1:0], DAT_I};

  assign ACK_O  = ack_q;
  assign DAT_O  = dat_q;
  assign data_o = data_q;
  assign ena_o  = ena_q;

  // Next-state logic: bus decode, register updates, FIFO bookkeeping, serializer FSM
  always_comb begin
    ack_d   = req & ~ack_q;
    dat_d   = '0;
    en_d    = en_q;
    msb_d   = msb_q;
    div_d   = div_q;
    ovf_d   = ovf_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    lvl_d   = lvl_q;
    state_d = state_q;
    tmr_d   = tmr_q;
    fdiv_d  = fdiv_q;
    fmsb_d  = fmsb_q;
    bits_d  = bits_q;
    sh_d    = sh_q;
    data_d  = data_q;
    ena_d   = ena_q;
    pop     = 1'b0;
    push    = 1'b0;

    status        = '0;
    status[0]     = empty;
    status[1]     = full;
    status[2]     = busy;
    status[3]     = ovf_q;
    status[15:8]  = 8'(lvl_q);

    // Read data is captured on the request cycle so it is valid while ACK_O is high
    if (req && !ack_q && !WE_I) begin
      unique case (sel)
        2'd0: dat_d = 32'(lvl_q);
        2'd1: dat_d = {30'b0, msb_q, en_q};
        2'd2: dat_d = 32'(div_q);
        default: dat_d = status;
      endcase
    end

    if (wr) begin
      unique case (sel)
        2'd1: begin
          en_d  = DAT_I[0];
          msb_d = DAT_I[1];
        end
        2'd2: div_d = DAT_I[DIV_W-1:0];
        2'd3: if (DAT_I[3]) ovf_d = 1'b0;
        default: ;
      endcase
    end

    unique case (state_q)
      S_IDLE: begin
        data_d = 1'b0;
        ena_d  = 1'b0;
        if (!empty && en_q) begin
          pop     = 1'b1;
          sh_d    = mem_q[rptr_q];
          fmsb_d  = msb_q;
          fdiv_d  = div_eff;
          tmr_d   = div_eff - DIV_W'(1);
          ena_d   = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (tmr_q == '0) begin
          ena_d   = 1'b0;
          data_d  = fmsb_q ? sh_q[DATA_W-1] : sh_q[0];
          sh_d    = fmsb_q ? (sh_q << 1) : (sh_q >> 1);
          bits_d  = '0;
          tmr_d   = fdiv_q - DIV_W'(1);
          state_d = S_SHIFT;
        end else begin
          tmr_d = tmr_q - DIV_W'(1);
        end
      end
      S_SHIFT: begin
        if (tmr_q == '0) begin
          if (bits_q == BIT_W'(DATA_W - 1)) begin
            data_d  = 1'b0;
            // GAP holds div-1 cycles; the IDLE cycle that follows completes the period
            tmr_d   = fdiv_q - DIV_W'(2);
            state_d = S_GAP;
          end else begin
            data_d = fmsb_q ? sh_q[DATA_W-1] : sh_q[0];
            sh_d   = fmsb_q ? (sh_q << 1) : (sh_q >> 1);
            bits_d = bits_q + BIT_W'(1);
            tmr_d  = fdiv_q - DIV_W'(1);
          end
        end else begin
          tmr_d = tmr_q - DIV_W'(1);
        end
      end
      default: begin
        data_d = 1'b0;
        ena_d  = 1'b0;
        if (tmr_q == '0) state_d = S_IDLE;
        else             tmr_d   = tmr_q - DIV_W'(1);
      end
    endcase

    // A full FIFO still accepts a word when the serializer pops in the same cycle
    if (wr && sel == 2'd0) begin
      if (!full || pop) push  = 1'b1;
      else              ovf_d = 1'b1;
    end

    if (push) wptr_d = wptr_q + PTR_W'(1);
    if (pop)  rptr_d = rptr_q + PTR_W'(1);
    if (push && !pop)      lvl_d = lvl_q + CNT_W'(1);
    else if (pop && !push) lvl_d = lvl_q - CNT_W'(1);
  end

  // FIFO storage; contents need no reset since the level counter is cleared
  always_ff @(posedge CLK_I) begin
    if (push) mem_q[wptr_q] <= DAT_I[DATA_W-1:0];
  end

  // State registers with synchronous reset
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q <= S_IDLE;
      ack_q   <= 1'b0;
      dat_q   <= '0;
      en_q    <= 1'b1;
      msb_q   <= 1'b0;
      div_q   <= DIV_W'(DIV_RST);
      ovf_q   <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      lvl_q   <= '0;
      tmr_q   <= '0;
      fdiv_q  <= '0;
      fmsb_q  <= 1'b0;
      bits_q  <= '0;
      sh_q    <= '0;
      data_q  <= 1'b0;
      ena_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      en_q    <= en_d;
      msb_q   <= msb_d;
      div_q   <= div_d;
      ovf_q   <= ovf_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      lvl_q   <= lvl_d;
      tmr_q   <= tmr_d;
      fdiv_q  <= fdiv_d;
      fmsb_q  <= fmsb_d;
      bits_q  <= bits_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      ena_q   <= ena_d;
    end
  end

endmodule

// File: tb/tb_wb_serial_tx.sv
// Self-checking bench for wb_serial_tx: register vectors from a table, serial
// frames checked by a monitor against a queue of expected frames.
module tb_wb_serial_tx;

  localparam int unsigned DATA_W = 10;

  logic        clk;
  logic        RST_I, CYC_I, STB_I, WE_I;
  logic [31:0] ADR_I, DAT_I, DAT_O;
  logic        ACK_O, data_o, ena_o;

  int unsigned pass_cnt  = 0;
  int unsigned total_cnt = 0;
  int unsigned cyc_cnt   = 0;
  int unsigned last_rise = 0;

  typedef struct {
    logic [31:0] word;
    int unsigned div;
    bit          msb;
    int unsigned gap;   // expected cycles since previous ena_o rise, 0 = not checked
  } frame_t;

  typedef struct {
    bit          we;
    logic [31:0] adr;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  frame_t exp_q[$];

  wb_serial_tx #(
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(8),
    .DIV_W     (16),
    .DIV_RST   (4)
  ) dut (
    .CLK_I (clk),
    .RST_I (RST_I),
    .CYC_I (CYC_I),
    .STB_I (STB_I),
    .WE_I  (WE_I),
    .ADR_I (ADR_I),
    .DAT_I (DAT_I),
    .DAT_O (DAT_O),
    .ACK_O (ACK_O),
    .data_o(data_o),
    .ena_o (ena_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic wb_xfer(input bit we, input logic [31:0] adr, input logic [31:0] wd,
                         output logic [31:0] rd);
    int n;
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = we; ADR_I = adr; DAT_I = wd;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ACK_O && n < 8);
    check("ack", ACK_O, 1);
    rd = DAT_O;
    @(posedge clk); #1;
    CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] wd);
    logic [31:0] dummy;
    wb_xfer(1'b1, adr, wd, dummy);
  endtask

  task automatic wb_read_check(input string name, input logic [31:0] adr, input logic [31:0] exp);
    logic [31:0] rd;
    wb_xfer(1'b0, adr, 32'h0, rd);
    check(name, rd, exp);
  endtask

  // Decode one frame starting at an ena_o rise; abandons on reset
  task automatic mon_frame();
    frame_t      e;
    int unsigned len, pos, target, idx;
    logic [31:0] got;
    check("frame_expected", 32'(exp_q.size() != 0), 1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    if (e.gap != 0) check("frame_interval", cyc_cnt - last_rise, e.gap);
    last_rise = cyc_cnt;
    len = 1;
    forever begin
      @(negedge clk);
      if (RST_I) return;
      if (!ena_o || len >= 200) break;
      len++;
    end
    check("start_len", len, e.div);
    got = '0;
    pos = 0;
    for (int i = 0; i <= DATA_W; i++) begin
      target = i * e.div + e.div / 2;
      while (pos < target) begin
        @(negedge clk);
        if (RST_I) return;
        pos++;
      end
      if (i < DATA_W) begin
        idx = e.msb ? (DATA_W - 1 - i) : i;
        got[idx] = data_o;
      end else begin
        check("gap_outputs", {30'b0, ena_o, data_o}, 0);
      end
    end
    check("frame_word", got, e.word);
  endtask

  // Frame monitor
  initial begin : monitor
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (RST_I) begin
        prev = 1'b0;
      end else if (ena_o && !prev) begin
        mon_frame();
        prev = RST_I ? 1'b0 : ena_o;
      end else begin
        prev = ena_o;
      end
    end
  end

  function automatic frame_t mk(input logic [31:0] w, input int unsigned d,
                                input bit m, input int unsigned g);
    frame_t f;
    f.word = w; f.div = d; f.msb = m; f.gap = g;
    return f;
  endfunction

  initial begin : main
    vec_t        vecs[13];
    int unsigned rises;
    logic        prev_ena;

    vecs[0]  = '{1'b0, 32'hC,  32'h0,         32'h1};
    vecs[1]  = '{1'b0, 32'h4,  32'h0,         32'h1};
    vecs[2]  = '{1'b0, 32'h8,  32'h0,         32'h4};
    vecs[3]  = '{1'b0, 32'h0,  32'h0,         32'h0};
    vecs[4]  = '{1'b1, 32'h4,  32'h2,         32'h0};
    vecs[5]  = '{1'b0, 32'h4,  32'h0,         32'h2};
    vecs[6]  = '{1'b1, 32'h8,  32'hFFFF_0007, 32'h0};
    vecs[7]  = '{1'b0, 32'h8,  32'h0,         32'h7};
    vecs[8]  = '{1'b0, 32'h10, 32'h0,         32'h0};
    vecs[9]  = '{1'b1, 32'h4,  32'h1,         32'h0};
    vecs[10] = '{1'b1, 32'h8,  32'h4,         32'h0};
    vecs[11] = '{1'b0, 32'h4,  32'h0,         32'h1};
    vecs[12] = '{1'b0, 32'h8,  32'h0,         32'h4};

    RST_I = 1'b1; CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
    ADR_I = '0; DAT_I = '0;
    repeat (10) @(posedge clk);
    #1;
    check("rst_ack",   {31'b0, ACK_O},  0);
    check("rst_dat",   DAT_O,           0);
    check("rst_data",  {31'b0, data_o}, 0);
    check("rst_ena",   {31'b0, ena_o},  0);
    RST_I = 1'b0;
    @(posedge clk); #1;

    // Register map vectors
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].we) wb_write(vecs[i].adr, vecs[i].wd);
      else            wb_read_check($sformatf("vec%0d", i), vecs[i].adr, vecs[i].exp);
    end

    // Single default frame and its start latency
    exp_q.push_back(mk(32'h201, 4, 1'b0, 0));
    wb_write(32'h0, 32'h0003_0201);
    check("lat_ena_low", {31'b0, ena_o}, 0);
    @(posedge clk); #1;
    check("lat_ena_high", {31'b0, ena_o}, 1);
    repeat (60) @(posedge clk);
    #1;
    wb_read_check("status_idle", 32'hC, 32'h1);

    // Fill past full with the serializer disabled
    wb_write(32'h4, 32'h0);
    for (int i = 0; i < 9; i++) wb_write(32'h0, 32'(i));
    wb_read_check("status_full_ovf", 32'hC, 32'h0000_080A);
    wb_read_check("level_full", 32'h0, 32'h8);
    wb_write(32'hC, 32'h8);
    wb_read_check("status_ovf_clr", 32'hC, 32'h0000_0802);
    for (int i = 0; i < 8; i++) exp_q.push_back(mk(32'(i), 4, 1'b0, (i == 0) ? 0 : 48));
    wb_write(32'h4, 32'h1);
    repeat (8 * 48 + 30) @(posedge clk);
    #1;
    wb_read_check("status_drained", 32'hC, 32'h1);

    // MSB-first at minimum divider, then divider change and disable mid-frame
    wb_write(32'h4, 32'h3);
    wb_write(32'h8, 32'h1);
    exp_q.push_back(mk(32'h201, 2, 1'b1, 0));
    exp_q.push_back(mk(32'h0F3, 6, 1'b1, 24));
    wb_write(32'h0, 32'h201);
    wb_write(32'h8, 32'h6);
    wb_write(32'h0, 32'h0F3);
    repeat (30) @(posedge clk);
    #1;
    wb_write(32'h4, 32'h0);
    wb_write(32'h0, 32'h03C);
    repeat (100) @(posedge clk);
    #1;
    wb_read_check("status_held", 32'hC, 32'h0000_0100);
    wb_read_check("div_readback", 32'h8, 32'h6);

    // Reset flushes the FIFO and restores registers
    RST_I = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    RST_I = 1'b0;
    wb_read_check("status_after_rst", 32'hC, 32'h1);
    wb_read_check("ctrl_after_rst",   32'h4, 32'h1);
    wb_read_check("div_after_rst",    32'h8, 32'h4);

    // Reset during bit 4 of a frame abandons it
    exp_q.push_back(mk(32'h155, 4, 1'b0, 0));
    wb_write(32'h0, 32'h155);
    repeat (22) @(posedge clk);
    #1;
    check("bit4_before_rst", {30'b0, ena_o, data_o}, 32'h1);
    RST_I = 1'b1;
    @(posedge clk); #1;
    check("outputs_after_rst", {30'b0, ena_o, data_o}, 0);
    RST_I = 1'b0;
    wb_read_check("status_abandon", 32'hC, 32'h1);
    rises = 0;
    prev_ena = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (ena_o && !prev_ena) rises++;
      prev_ena = ena_o;
    end
    check("no_frame_after_rst", rises, 0);
    check("frames_pending", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/wb_serial_tx.md
# wb_serial_tx

Wishbone-slave serial transmitter for the acquisition datapath. It replaces the single-register serializer with a parametrised block. Words written over Wishbone queue in a FIFO. Each word is shifted out on `data_o` as a framed serial word, with a one-bit-period `ena_o` start slot before it. Word width, FIFO depth, bit period and bit order are configurable. The bus side stays compatible with existing benches: a write to address 0x0 transmits immediately with the default settings.

## Interface
- `DATA_W`, 10, serial word width in bits (1..32)
- `FIFO_DEPTH`, 8, transmit FIFO entries (power of two, ≥2)
- `DIV_W`, 16, width of the bit-period divider register
- `DIV_RST`, 4, divider reset value (clock cycles per bit)
- Clock and reset: one clock; reset is synchronous and active-high.
- `CLK_I`  in  1  system clock
- `RST_I`  in  1  synchronous reset, active-high
- `CYC_I`, `STB_I`, `WE_I`  in  1 each  Wishbone cycle, strobe, write enable
- `ADR_I`  in  32  byte address; only `ADR_I[3:2]` is decoded
- `DAT_I`  in  32  write data
- `DAT_O`  out  32  read data
- `ACK_O`  out  1  single-cycle acknowledge
- `data_o`  out  1  serial data
- `ena_o`  out  1  frame start slot

## Operation
- Register map:
  - 0x0 DATA: a write pushes `DAT_I[DATA_W-1:0]`. A read returns the FIFO level.
  - 0x4 CTRL: bit0 `en` (reset 1), bit1 `msb_first` (reset 0).
  - 0x8 DIV: `[DIV_W-1:0]`, reset `DIV_RST`.
  - 0xC STATUS (read): bit0 empty, bit1 full, bit2 busy, bit3 overflow (sticky), bits[15:8] level. Writing 1 to bit3 clears overflow.
- Unused read bits return 0.
- Bus: `ACK_O` is registered and equals `CYC_I & STB_I & ~ACK_O` from the previous cycle. The write or read takes effect in the cycle `ACK_O` is high. There are no wait states and no error or retry.
- DATA write while the FIFO is full: the word is dropped, overflow is set and ACK is still given.
- DATA write on the same cycle as a serializer pop while full: the write is accepted.
- Serializer FSM:
  - IDLE:
    - Stay while the FIFO is empty or `en` = 0.
    - Otherwise pop the head word, latch DIV and `msb_first`, and go to START.
    - Effective divider is max(DIV, 2).
  - START: `ena_o` = 1 and `data_o` = 0 for one bit period, then go to SHIFT.
  - SHIFT:
    - Drive `DATA_W` bits, one per bit period, LSB first unless `msb_first` is set.
    - `ena_o` = 0. After the last bit, go to GAP.
  - GAP:
    - `data_o` = 0 and `ena_o` = 0 for one bit period, then return to IDLE.
    - Start the next frame on the following cycle if one is eligible.
- Clearing `en` mid-frame completes the current frame and stops at IDLE.
- DIV and CTRL writes mid-frame apply from the next frame.
- busy = state ≠ IDLE.
- Reset at any point:
  - Outputs go to 0 and the FSM goes to IDLE.
  - The FIFO is flushed, registers return to reset values and overflow is cleared.
  - The partial frame is abandoned; no resumption.

## Timing
- Reset values: `ACK_O` = 0, `DAT_O` = 0, `data_o` = 0, `ena_o` = 0.
- `data_o` and `ena_o` are registered and change only at bit-period boundaries.
- Latency: a DATA write is acked in cycle T, the FIFO is non-empty in T+1, and `ena_o` rises in T+2 when the block is idle and enabled.
- Frame length: (DATA_W + 2) × div cycles, including START and GAP.
- A bit sampled mid-period (div/2 cycles after the boundary) is stable.
- Level counter: 0..FIFO_DEPTH.
- Read and write pointers are log2(FIFO_DEPTH) bits and wrap modulo depth.
- STATUS and level reflect state one cycle after the ACK cycle.

## Test plan
- Reset for 10 cycles, then release → all outputs 0, STATUS = 0x00000001, CTRL = 0x1, DIV = 4.
- Write 0x30201 to 0x0 (DATA_W = 10, div = 4) → `ena_o` high 4 cycles. Bits LSB-first are 1,0,0,0,0,0,0,0,0,1, i.e. 0x201 = 513. GAP follows, then idle.
- Set CTRL = 0, write 9 words 0..8 to DATA → level 8, full = 1, overflow = 1. Set CTRL = 1 → 8 frames carrying 0..7 back-to-back, each 48 cycles apart.
- Set CTRL = 0x3 and DIV = 1, write 0x201 → MSB-first bits 1,0,0,0,0,0,0,0,0,1 at 2 cycles per bit. Then DIV = 6 mid-frame → the current frame stays at 2 cycles per bit and the next frame uses 6.
- Write 0x155, then assert `RST_I` during bit 4 → `data_o`/`ena_o` are 0 the next cycle, the FIFO is empty and no further frame is produced.
- Write 1 to STATUS bit3 after overflow → overflow is 0 on the next read, while level and full are unchanged.
